// File: rtl/regfile_port_arbiter_pkg.sv
// Shared definitions for the register-file port-b arbiter: hardware-owned
// register addresses and arbiter state encodings.
package regfile_port_arbiter_pkg;

  localparam int REG_AW = 5;

  // Registers written only by hardware; software writes are suppressed
  localparam logic [REG_AW-1:0] DINP = 5'd30;
  localparam logic [REG_AW-1:0] RAND = 5'd31;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_GRANT  = 2'd1,
    ST_LOCKED = 2'd2
  } arb_state_e;

  function automatic logic is_protected(input logic [REG_AW-1:0] addr);
    return (addr == DINP) || (addr == RAND);
  endfunction

endpackage

// File: rtl/regfile_port_arbiter_if.sv
// Requester-side and register-file-side signals of the port-b arbiter.
interface regfile_port_arbiter_if #(
  parameter int NUM_REQ = 3,
  parameter int AW      = 5,
  parameter int DW      = 8
);
  logic                  hold;
  logic [NUM_REQ-1:0]    req;
  logic [NUM_REQ-1:0]    lock;
  logic [NUM_REQ*AW-1:0] req_addr;
  logic [NUM_REQ*DW-1:0] req_wdata;
  logic [NUM_REQ-1:0]    req_wr;
  logic [NUM_REQ-1:0]    gnt;
  logic [DW-1:0]         rdata;
  logic [NUM_REQ-1:0]    protect_err;
  logic [AW-1:0]         b_addr;
  logic [DW-1:0]         b_data_in;
  logic                  b_wr_enable;
  logic [DW-1:0]         b_data_out;

  modport master (
    output hold, req, lock, req_addr, req_wdata, req_wr, b_data_out,
    input  gnt, rdata, protect_err, b_addr, b_data_in, b_wr_enable
  );

  modport slave (
    input  hold, req, lock, req_addr, req_wdata, req_wr, b_data_out,
    output gnt, rdata, protect_err, b_addr, b_data_in, b_wr_enable
  );
endinterface

// File: rtl/regfile_port_arbiter_rr_priority_pick.sv
// Combinational round-robin pick: first set candidate at or above rr_ptr,
// wrapping around; returns a one-hot winner and a valid flag.
module rr_priority_pick #(
  parameter int NUM_REQ = 3,
  localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic [NUM_REQ-1:0] cand,
  input  logic [PW-1:0]      rr_ptr,
  output logic [NUM_REQ-1:0] onehot,
  output logic               valid
);

  logic [PW-1:0] idx_s;

  // Walk candidates from rr_ptr upward; the first hit masks all later ones
  always_comb begin
    onehot = '0;
    valid  = 1'b0;
    idx_s  = '0;
    for (int off = 0; off < NUM_REQ; off++) begin
      idx_s         = PW'((int'(rr_ptr) + off) % NUM_REQ);
      onehot[idx_s] = ~valid & cand[idx_s];
      valid         = valid | cand[idx_s];
    end
  end

endmodule

// File: rtl/regfile_port_arbiter.sv
// Round-robin arbiter sharing register-file port b between requesters, with
// multi-cycle lock for atomic read-modify-write and write protection.
module regfile_port_arbiter
  import regfile_port_arbiter_pkg::*;
#(
  parameter int NUM_REQ = 3,
  parameter int AW      = 5,
  parameter int DW      = 8
) (
  input  logic                  clk,
  input  logic                  resetn,
  regfile_port_arbiter_if.slave bus
);

  localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam logic [NUM_REQ-1:0] ONE = {{(NUM_REQ-1){1'b0}}, 1'b1};

  arb_state_e         state_r, state_n;
  logic [NUM_REQ-1:0] gnt_r, gnt_n;
  logic [PW-1:0]      owner_r, owner_n;
  logic [PW-1:0]      rr_r, rr_n;

  logic [NUM_REQ-1:0] cand_s, pick_onehot_s;
  logic               pick_valid_s;
  logic [PW-1:0]      pick_idx_s;

  logic [AW-1:0]      owner_addr_s;
  logic [DW-1:0]      owner_wdata_s;
  logic               owner_wr_s, owner_lock_s, owner_prot_s;
  logic               any_gnt_s, lock_cont_s, rr_upd_s;

  // The current grantee is excluded so a single req pulse yields one grant
  assign cand_s = bus.req & ~gnt_r;

  rr_priority_pick #(.NUM_REQ(NUM_REQ)) u_pick (
    .cand   (cand_s),
    .rr_ptr (rr_r),
    .onehot (pick_onehot_s),
    .valid  (pick_valid_s)
  );

  // One-hot winner to index
  always_comb begin
    pick_idx_s = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      pick_idx_s = pick_idx_s | (pick_onehot_s[i] ? PW'(i) : '0);
    end
  end

  // Owner's request fields
  always_comb begin
    owner_addr_s  = bus.req_addr[int'(owner_r)*AW +: AW];
    owner_wdata_s = bus.req_wdata[int'(owner_r)*DW +: DW];
    owner_wr_s    = bus.req_wr[owner_r];
    owner_lock_s  = bus.lock[owner_r];
    owner_prot_s  = is_protected(REG_AW'(owner_addr_s));
    any_gnt_s     = |gnt_r;
  end

  // A held LOCKED state (gnt=0) keeps its lock until resumed and released
  always_comb begin
    lock_cont_s = ((state_r == ST_LOCKED) && (!any_gnt_s || owner_lock_s)) ||
                  ((state_r == ST_GRANT) && owner_lock_s);
    rr_upd_s    = !bus.hold && any_gnt_s &&
                  ((state_r == ST_GRANT) || !owner_lock_s);
  end

  // Next-state, grant and pointer logic
  always_comb begin
    state_n = state_r;
    gnt_n   = gnt_r;
    owner_n = owner_r;
    rr_n    = rr_r;
    if (bus.hold) begin
      gnt_n   = '0;
      state_n = lock_cont_s ? ST_LOCKED : ST_IDLE;
    end else if (lock_cont_s) begin
      gnt_n   = ONE << owner_r;
      state_n = ST_LOCKED;
    end else if (pick_valid_s) begin
      gnt_n   = pick_onehot_s;
      owner_n = pick_idx_s;
      state_n = ST_GRANT;
    end else begin
      gnt_n   = '0;
      state_n = ST_IDLE;
    end
    if (rr_upd_s) begin
      rr_n = (owner_r == PW'(NUM_REQ - 1)) ? '0 : owner_r + PW'(1);
    end else begin
      rr_n = rr_r;
    end
  end

  // State, grant, owner and round-robin pointer registers
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_r <= ST_IDLE;
      gnt_r   <= '0;
      owner_r <= '0;
      rr_r    <= '0;
    end else begin
      state_r <= state_n;
      gnt_r   <= gnt_n;
      owner_r <= owner_n;
      rr_r    <= rr_n;
    end
  end

  assign bus.gnt = gnt_r;

  // Port-b drive and error flag follow the live grant cycle
  always_comb begin
    if (any_gnt_s) begin
      bus.b_addr      = owner_addr_s;
      bus.b_data_in   = owner_wdata_s;
      bus.b_wr_enable = owner_wr_s & ~owner_prot_s;
      bus.rdata       = bus.b_data_out;
      bus.protect_err = gnt_r & {NUM_REQ{owner_wr_s & owner_prot_s}};
    end else begin
      bus.b_addr      = '0;
      bus.b_data_in   = '0;
      bus.b_wr_enable = 1'b0;
      bus.rdata       = '0;
      bus.protect_err = '0;
    end
  end

endmodule

// File: tb/tb_regfile_port_arbiter.sv
// Directed self-checking bench for regfile_port_arbiter with a small
// register-file model on port b.
module tb_regfile_port_arbiter;

  logic clk;
  logic resetn;
  logic init_mem;
  logic [7:0] mem [0:31];
  int n_cmp = 0;
  int n_err = 0;

  regfile_port_arbiter_if #(.NUM_REQ(3), .AW(5), .DW(8)) bus_if ();

  regfile_port_arbiter #(.NUM_REQ(3), .AW(5), .DW(8)) dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Register file: DINP (30) holds 8'h5A, register 5 holds 8'h10
  always @(posedge clk) begin
    if (init_mem) begin
      for (int i = 0; i < 32; i++) mem[i] <= 8'h00;
      mem[5]  <= 8'h10;
      mem[30] <= 8'h5A;
      mem[31] <= 8'h77;
    end else if (bus_if.b_wr_enable) begin
      mem[bus_if.b_addr] <= bus_if.b_data_in;
    end
  end

  assign bus_if.b_data_out = mem[bus_if.b_addr];

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic set_req(input int i, input logic r, input logic lk, input logic wr,
                         input logic [4:0] a, input logic [7:0] d);
    bus_if.req[i]            = r;
    bus_if.lock[i]           = lk;
    bus_if.req_wr[i]         = wr;
    bus_if.req_addr[i*5 +: 5]  = a;
    bus_if.req_wdata[i*8 +: 8] = d;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  logic [2:0] rr_seq [6];

  initial begin
    rr_seq = '{3'b001, 3'b010, 3'b100, 3'b001, 3'b010, 3'b100};
    bus_if.hold = 1'b0;
    bus_if.req = 3'b000;
    bus_if.lock = 3'b000;
    bus_if.req_wr = 3'b000;
    bus_if.req_addr = 15'd0;
    bus_if.req_wdata = 24'd0;
    resetn = 1'b0;
    init_mem = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check_val("rst_gnt", 32'(bus_if.gnt), 32'd0);
    check_val("rst_perr", 32'(bus_if.protect_err), 32'd0);
    check_val("rst_wren", 32'(bus_if.b_wr_enable), 32'd0);
    check_val("rst_rdata", 32'(bus_if.rdata), 32'd0);
    init_mem = 1'b0;
    resetn = 1'b1;

    // Single write pulse from requester 1
    set_req(1, 1'b1, 1'b0, 1'b1, 5'd3, 8'hA5);
    #1 check_val("t1_pre_gnt", 32'(bus_if.gnt), 32'd0);
    step(); bus_if.req[1] = 1'b0;
    #1 check_val("t1_gnt", 32'(bus_if.gnt), 32'b010);
    check_val("t1_wren", 32'(bus_if.b_wr_enable), 32'd1);
    check_val("t1_addr", 32'(bus_if.b_addr), 32'd3);
    check_val("t1_din", 32'(bus_if.b_data_in), 32'hA5);
    step(); set_req(1, 1'b0, 1'b0, 1'b0, 5'd0, 8'h00);
    #1 check_val("t1_once", 32'(bus_if.gnt), 32'd0);
    check_val("t1_wren_off", 32'(bus_if.b_wr_enable), 32'd0);

    // Read back register 3 via requester 0, then register 5 via requester 2
    set_req(0, 1'b1, 1'b0, 1'b0, 5'd3, 8'h00);
    step(); bus_if.req[0] = 1'b0;
    #1 check_val("rd3_gnt", 32'(bus_if.gnt), 32'b001);
    check_val("rd3_data", 32'(bus_if.rdata), 32'hA5);
    step(); set_req(0, 1'b0, 1'b0, 1'b0, 5'd0, 8'h00);
    set_req(2, 1'b1, 1'b0, 1'b0, 5'd5, 8'h00);
    step(); bus_if.req[2] = 1'b0;
    #1 check_val("rd5_gnt", 32'(bus_if.gnt), 32'b100);
    check_val("rd5_data", 32'(bus_if.rdata), 32'h10);
    step(); set_req(2, 1'b0, 1'b0, 1'b0, 5'd0, 8'h00);

    // Contention from rr_ptr=0: order 0,1,2,0,1,2
    for (int i = 0; i < 3; i++) set_req(i, 1'b1, 1'b0, 1'b0, 5'(i), 8'h00);
    for (int k = 0; k < 6; k++) begin
      step();
      if (k == 5) bus_if.req = 3'b000;
      #1 check_val($sformatf("rr_gnt%0d", k), 32'(bus_if.gnt), 32'(rr_seq[k]));
      check_val($sformatf("rr_addr%0d", k), 32'(bus_if.b_addr), 32'(k % 3));
    end
    step(); #1 check_val("rr_idle", 32'(bus_if.gnt), 32'd0);

    // Locked read-modify-write by requester 2 while 0 and 1 wait
    set_req(2, 1'b1, 1'b1, 1'b0, 5'd5, 8'h00);
    step();
    set_req(0, 1'b1, 1'b0, 1'b0, 5'd0, 8'h00);
    set_req(1, 1'b1, 1'b0, 1'b0, 5'd1, 8'h00);
    #1 check_val("rmw_rd_gnt", 32'(bus_if.gnt), 32'b100);
    check_val("rmw_rd_data", 32'(bus_if.rdata), 32'h10);
    check_val("rmw_rd_wren", 32'(bus_if.b_wr_enable), 32'd0);
    step(); set_req(2, 1'b0, 1'b0, 1'b1, 5'd5, 8'h11);
    #1 check_val("rmw_wr_gnt", 32'(bus_if.gnt), 32'b100);
    check_val("rmw_wr_wren", 32'(bus_if.b_wr_enable), 32'd1);
    check_val("rmw_wr_din", 32'(bus_if.b_data_in), 32'h11);
    step(); bus_if.req[0] = 1'b0; bus_if.req[1] = 1'b0;
    set_req(2, 1'b0, 1'b0, 1'b0, 5'd0, 8'h00);
    #1 check_val("rmw_next", 32'(bus_if.gnt), 32'b001);
    step(); set_req(0, 1'b1, 1'b0, 1'b0, 5'd5, 8'h00);
    #1 check_val("rmw_idle", 32'(bus_if.gnt), 32'd0);
    step(); bus_if.req[0] = 1'b0;
    #1 check_val("rmw_result", 32'(bus_if.rdata), 32'h11);
    step(); set_req(0, 1'b0, 1'b0, 1'b0, 5'd0, 8'h00);

    // Write to DINP is suppressed and flagged
    set_req(0, 1'b1, 1'b0, 1'b1, 5'd30, 8'hFF);
    step(); bus_if.req[0] = 1'b0;
    #1 check_val("prot_gnt", 32'(bus_if.gnt), 32'b001);
    check_val("prot_wren", 32'(bus_if.b_wr_enable), 32'd0);
    check_val("prot_err", 32'(bus_if.protect_err), 32'b001);
    step(); set_req(0, 1'b1, 1'b0, 1'b0, 5'd30, 8'h00);
    #1 check_val("prot_err_end", 32'(bus_if.protect_err), 32'd0);
    step(); bus_if.req[0] = 1'b0;
    #1 check_val("prot_rd_data", 32'(bus_if.rdata), 32'h5A);
    check_val("prot_rd_err", 32'(bus_if.protect_err), 32'd0);
    step(); set_req(0, 1'b0, 1'b0, 1'b0, 5'd0, 8'h00);

    // Hold while requester 1 is locked
    set_req(1, 1'b1, 1'b1, 1'b0, 5'd3, 8'h00);
    step();
    bus_if.req[1] = 1'b0;
    set_req(0, 1'b1, 1'b0, 1'b0, 5'd0, 8'h00);
    set_req(2, 1'b1, 1'b0, 1'b0, 5'd2, 8'h00);
    bus_if.hold = 1'b1;
    #1 check_val("hold_first", 32'(bus_if.gnt), 32'b010);
    for (int k = 0; k < 3; k++) begin
      step();
      if (k == 2) bus_if.hold = 1'b0;
      #1 check_val($sformatf("hold_gap%0d", k), 32'(bus_if.gnt), 32'd0);
    end
    step(); bus_if.lock[1] = 1'b0;
    #1 check_val("hold_resume", 32'(bus_if.gnt), 32'b010);
    check_val("hold_rdata", 32'(bus_if.rdata), 32'hA5);
    step();
    for (int i = 0; i < 3; i++) set_req(i, 1'b0, 1'b0, 1'b0, 5'd0, 8'h00);
    #1 check_val("hold_after", 32'(bus_if.gnt), 32'b100);
    step(); #1 check_val("hold_idle", 32'(bus_if.gnt), 32'd0);

    // Reset while requester 0 holds a lock
    set_req(0, 1'b1, 1'b1, 1'b0, 5'd0, 8'h00);
    step(); #1 check_val("lk_gnt", 32'(bus_if.gnt), 32'b001);
    step(); #1 check_val("lk_held", 32'(bus_if.gnt), 32'b001);
    #2 resetn = 1'b0;
    #1 check_val("async_rst", 32'(bus_if.gnt), 32'd0);
    set_req(0, 1'b0, 1'b0, 1'b0, 5'd0, 8'h00);
    step(); step(); resetn = 1'b1;
    set_req(0, 1'b1, 1'b0, 1'b0, 5'd0, 8'h00);
    set_req(1, 1'b1, 1'b0, 1'b0, 5'd1, 8'h00);
    step(); bus_if.req = 3'b000;
    #1 check_val("rst_rrptr", 32'(bus_if.gnt), 32'b001);
    step(); set_req(2, 1'b1, 1'b0, 1'b0, 5'd2, 8'h00);
    #1 check_val("rst_idle", 32'(bus_if.gnt), 32'd0);
    step(); bus_if.req[2] = 1'b0;
    #1 check_val("post_rst", 32'(bus_if.gnt), 32'b100);
    step(); #1 check_val("post_idle", 32'(bus_if.gnt), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
